// File: rtl/count_frame_tx_if.sv
// count_frame_tx_if
//   Byte-wide valid/ready stream carrying counter snapshot frames toward the
//   board-level UART/debug sink.
//   TxValid  : source -> sink, TxData/TxLast are meaningful
//   TxData   : source -> sink, current frame byte
//   TxLast   : source -> sink, marks the checksum (final) byte of a frame
//   TxReady  : sink -> source, sink accepts the byte at this rising edge
//   master modport is the frame transmitter, slave modport is the sink.
interface count_frame_tx_if;
  logic       TxValid;
  logic [7:0] TxData;
  logic       TxLast;
  logic       TxReady;

  modport master (
    output TxValid,
    output TxData,
    output TxLast,
    input  TxReady
  );

  modport slave (
    input  TxValid,
    input  TxData,
    input  TxLast,
    output TxReady
  );
endinterface

// File: rtl/count_frame_tx.sv
// count_frame_tx
//   Snapshots one of two 64-bit counter values on a capture request and sends
//   it as a 10-byte frame: header {HDR_TAG, 3'b000, slt}, eight data bytes
//   MSB-first, then the XOR of the eight data bytes (header excluded).
//   Requests that arrive while a frame is in flight are dropped and counted.
// Ports
//   Clk    : system clock, rising edge
//   Reset  : asynchronous reset, active low
//   Req    : capture request
//   Slt    : source select at capture (0 = In0, 1 = In1)
//   In0    : counter value 0
//   In1    : counter value 1
//   tx     : byte stream toward the sink (master side)
//   Busy   : a frame is in flight
//   Drop   : saturating count of dropped requests
module count_frame_tx #(
  parameter logic [3:0] HDR_TAG = 4'hA
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Req,
  input  logic                   Slt,
  input  logic [63:0]            In0,
  input  logic [63:0]            In1,
  count_frame_tx_if.master       tx,
  output logic                   Busy,
  output logic [7:0]             Drop
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] snap_q,  snap_d;
  logic        slt_q,   slt_d;
  logic [2:0]  idx_q,   idx_d;
  logic [7:0]  csum_q,  csum_d;
  logic [7:0]  drop_q,  drop_d;

  logic        tx_valid;
  logic [7:0]  data_byte;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic        hs;
  logic        capture;
  logic        drop_inc;

  // Output decode: everything the sink sees depends on registered state
  // only, so TxReady never reaches TxValid/TxData combinationally.
  always_comb begin
    tx_valid  = (state_q != IDLE);
    tx_last   = (state_q == CSUM);
    // ~idx_q == 7 - idx_q, so index 0 selects bits [63:56].
    data_byte = snap_q[{~idx_q, 3'b000} +: 8];
    tx_data   = 8'h00;
    case (state_q)
      HDR:     tx_data = {HDR_TAG, 3'b000, slt_q};
      DATA:    tx_data = data_byte;
      CSUM:    tx_data = csum_q;
      default: tx_data = 8'h00;
    endcase
  end

  assign hs         = tx_valid & tx.TxReady;
  assign tx.TxValid = tx_valid;
  assign tx.TxData  = tx_data;
  assign tx.TxLast  = tx_last;
  assign Busy       = (state_q != IDLE);
  assign Drop       = drop_q;

  // Next-state, snapshot, checksum and drop counter.
  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    slt_d    = slt_q;
    idx_d    = idx_q;
    csum_d   = csum_q;
    drop_d   = drop_q;
    capture  = 1'b0;
    drop_inc = 1'b0;

    case (state_q)
      IDLE: begin
        capture = Req;
      end
      HDR: begin
        drop_inc = Req;
        if (hs) begin
          state_d = DATA;
          idx_d   = 3'd0;
        end
      end
      DATA: begin
        drop_inc = Req;
        if (hs) begin
          csum_d = csum_q ^ data_byte;
          idx_d  = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (hs) begin
          // A request on the final handshake starts the next frame with no
          // IDLE cycle in between.
          if (Req) begin
            capture = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          drop_inc = Req;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (capture) begin
      snap_d  = Slt ? In1 : In0;
      slt_d   = Slt;
      csum_d  = 8'h00;
      state_d = HDR;
    end

    if (drop_inc && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      snap_q  <= 64'd0;
      slt_q   <= 1'b0;
      idx_q   <= 3'd0;
      csum_q  <= 8'h00;
      drop_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      slt_q   <= slt_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_count_frame_tx.sv
// tb_count_frame_tx
//   Directed bench for count_frame_tx: reset state, single capture, source
//   select with snapshot freeze, backpressure with dropped requests,
//   back-to-back capture, asynchronous reset mid-frame and drop saturation.
module tb_count_frame_tx;
  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req;
  logic        Slt;
  logic [63:0] In0;
  logic [63:0] In1;
  logic        Busy;
  logic [7:0]  Drop;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_b [10];

  count_frame_tx_if tx_if ();

  count_frame_tx #(.HDR_TAG(4'hA)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Req   (Req),
    .Slt   (Slt),
    .In0   (In0),
    .In1   (In1),
    .tx    (tx_if.master),
    .Busy  (Busy),
    .Drop  (Drop)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected frame: header, data bytes MSB-first, hand-computed checksum.
  task automatic set_frame(input logic [7:0] hdr, input logic [63:0] v, input logic [7:0] csum);
    exp_b[0] = hdr;
    for (int i = 0; i < 8; i++) begin
      exp_b[i+1] = v[63-8*i -: 8];
    end
    exp_b[9] = csum;
  endtask

  // Entered at a falling edge where the header is being presented.
  // mode 0: TxReady always 1; mode 1: TxReady pattern 1,0,0 repeating.
  task automatic run_frame(input string tag, input int mode, input bit wiggle,
                           input bit stall_req, input bit b2b);
    int n;
    int cyc;
    logic [7:0] pd;
    logic pl;
    bit prev_stall;
    n = 0;
    cyc = 0;
    pd = 8'h00;
    pl = 1'b0;
    prev_stall = 1'b0;
    while (n < 10 && cyc < 200) begin
      tx_if.TxReady = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      Req = (stall_req && !tx_if.TxReady) || (b2b && tx_if.TxReady && n == 9);
      chk({tag, "_valid"}, tx_if.TxValid, 1);
      if (prev_stall) begin
        chk({tag, "_stall_data"}, tx_if.TxData, pd);
        chk({tag, "_stall_last"}, tx_if.TxLast, pl);
      end
      if (tx_if.TxReady) begin
        chk({tag, "_byte"}, tx_if.TxData, exp_b[n]);
        chk({tag, "_last"}, tx_if.TxLast, (n == 9));
        n++;
      end
      prev_stall = !tx_if.TxReady;
      pd = tx_if.TxData;
      pl = tx_if.TxLast;
      @(negedge Clk);
      if (wiggle) In1 = In1 + 64'h0101_0101_0101_0101;
      cyc++;
    end
    Req = 1'b0;
    chk({tag, "_complete"}, n, 10);
  endtask

  initial begin
    Reset = 1'b0;
    Req = 1'b0;
    Slt = 1'b0;
    In0 = 64'd0;
    In1 = 64'd0;
    tx_if.TxReady = 1'b0;

    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst_valid", tx_if.TxValid, 0);
    chk("rst_data", tx_if.TxData, 8'h00);
    chk("rst_last", tx_if.TxLast, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_drop", Drop, 8'h00);
    Reset = 1'b1;
    @(negedge Clk);
    chk("idle_valid", tx_if.TxValid, 0);

    // Single capture from In0; 01^23^45^67^89^AB^CD^EF = 00
    In0 = 64'h0123_4567_89AB_CDEF;
    Slt = 1'b0;
    tx_if.TxReady = 1'b1;
    Req = 1'b1;
    @(negedge Clk);
    Req = 1'b0;
    chk("t1_busy", Busy, 1);
    set_frame(8'hA0, 64'h0123_4567_89AB_CDEF, 8'h00);
    run_frame("t1", 0, 1'b0, 1'b0, 1'b0);
    chk("t1_gap_valid", tx_if.TxValid, 0);
    chk("t1_busy_after", Busy, 0);
    chk("t1_drop", Drop, 8'h00);

    // In1 select; In1 keeps changing after capture
    Slt = 1'b1;
    In1 = 64'h0000_0000_0000_0005;
    Req = 1'b1;
    @(negedge Clk);
    Req = 1'b0;
    set_frame(8'hA1, 64'h0000_0000_0000_0005, 8'h05);
    run_frame("t2", 0, 1'b1, 1'b0, 1'b0);
    chk("t2_gap_valid", tx_if.TxValid, 0);

    // Backpressure 1,0,0,...; Req on every stall cycle -> 18 drops
    Slt = 1'b0;
    In0 = 64'h0123_4567_89AB_CDEF;
    Req = 1'b1;
    @(negedge Clk);
    Req = 1'b0;
    set_frame(8'hA0, 64'h0123_4567_89AB_CDEF, 8'h00);
    run_frame("t3", 1, 1'b0, 1'b1, 1'b0);
    chk("t3_drop", Drop, 8'd18);

    // Back-to-back: 80^FF = 7F; then 11^22^33^44^55^66^77^88 = 88
    tx_if.TxReady = 1'b1;
    Slt = 1'b1;
    In1 = 64'h8000_0000_0000_00FF;
    Req = 1'b1;
    @(negedge Clk);
    Req = 1'b0;
    Slt = 1'b0;
    In0 = 64'h1122_3344_5566_7788;
    set_frame(8'hA1, 64'h8000_0000_0000_00FF, 8'h7F);
    run_frame("t4", 0, 1'b0, 1'b0, 1'b1);
    chk("t4_b2b_valid", tx_if.TxValid, 1);
    chk("t4_b2b_hdr", tx_if.TxData, 8'hA0);
    chk("t4_b2b_busy", Busy, 1);
    chk("t4_b2b_drop", Drop, 8'd18);
    set_frame(8'hA0, 64'h1122_3344_5566_7788, 8'h88);
    run_frame("t4b", 0, 1'b0, 1'b0, 1'b0);
    chk("t4b_gap_valid", tx_if.TxValid, 0);

    // Asynchronous reset while data byte 3 is presented
    In0 = 64'hDEAD_BEEF_0000_1111;
    Slt = 1'b0;
    Req = 1'b1;
    @(negedge Clk);
    Req = 1'b0;
    repeat (4) @(negedge Clk);
    chk("t5_d3", tx_if.TxData, 8'hEF);
    chk("t5_pre_drop", Drop, 8'd18);
    #2 Reset = 1'b0;
    #1;
    chk("t5_async_valid", tx_if.TxValid, 0);
    chk("t5_async_busy", Busy, 0);
    chk("t5_async_drop", Drop, 8'h00);
    chk("t5_async_data", tx_if.TxData, 8'h00);
    @(negedge Clk);
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk("t5_post_valid", tx_if.TxValid, 0);
    end

    // Req held high for 300+ cycles: no gaps, 9 drops per frame, saturate
    In0 = 64'h0102_0408_1020_4080;
    Slt = 1'b0;
    tx_if.TxReady = 1'b1;
    Req = 1'b1;
    for (int e = 0; e <= 300; e++) begin
      int exp_d;
      @(negedge Clk);
      exp_d = e - e / 10;
      if (exp_d > 255) exp_d = 255;
      chk("t6_valid", tx_if.TxValid, 1);
      chk("t6_drop", Drop, exp_d);
    end
    Req = 1'b0;
    set_frame(8'hA0, 64'h0102_0408_1020_4080, 8'hFF);
    run_frame("t6", 0, 1'b0, 1'b0, 1'b0);
    chk("t6_drop_final", Drop, 8'hFF);
    chk("t6_gap_valid", tx_if.TxValid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
